// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings,
// byte-lane count and the word-alignment mask.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int         LANES      = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/dmem_responder_array.sv
// Word-organised storage: combinational read, synchronous write with one
// write enable per byte lane. Contents are deliberately not reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [LANES-1:0] be,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Write only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the data-memory request/response interface. Accepts one
// request at a time, waits WAIT_CYCLES, performs the access in a single
// ACCESS cycle and holds the response until the requester takes it.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LANES-1:0]  req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t            state, state_next;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [LANES-1:0]  lat_be;

  logic              accept;
  logic              resp_fire;
  logic [ADDR_W-1:0] word_idx;
  logic              legal;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign accept    = req_valid && req_ready;
  assign resp_fire = resp_valid && resp_ready;

  // Out-of-range word indices are errors rather than aliases, so the full
  // shifted address is compared against the depth.
  assign word_idx = lat_addr >> 2;
  assign legal    = ((lat_addr[1:0] & ALIGN_MASK) == 2'b00) &&
                    (lat_be != '0) &&
                    (word_idx < ADDR_W'(DEPTH_WORDS));
  assign mem_we   = (state == ACCESS) && legal && lat_we;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .idx  (word_idx[IDX_W-1:0]),
    .be   (lat_be),
    .wdata(lat_wdata),
    .rdata(mem_rdata)
  );

  // State register; reset drops any pending request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and handshake outputs; req_ready is gated by reset directly.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst;
        if (accept) state_next = (WAIT_CYCLES > 0) ? BUSY : ACCESS;
      end
      BUSY: begin
        if (cnt == 4'd1) state_next = ACCESS;
      end
      ACCESS: begin
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, wait counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        cnt       <= 4'(WAIT_CYCLES);
      end
      if (state == BUSY) cnt <= cnt - 4'd1;
      if (state == ACCESS) begin
        resp_err   <= !legal;
        resp_rdata <= (legal && !lat_we) ? mem_rdata : '0;
      end
      if (resp_fire) begin
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a table of single transactions on a
// WAIT_CYCLES=2 instance plus hand-written back-pressure, reset and
// zero-wait-state sequences.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_valid, resp_ready = 1'b1, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid_z = 1'b0, req_ready_z, req_we_z = 1'b0;
  logic [31:0] req_addr_z = '0, req_wdata_z = '0;
  logic [3:0]  req_be_z = '0;
  logic        resp_valid_z, resp_ready_z = 1'b1, resp_err_z;
  logic [31:0] resp_rdata_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_we(req_we_z),
    .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_be(req_be_z),
    .resp_valid(resp_valid_z), .resp_ready(resp_ready_z),
    .resp_rdata(resp_rdata_z), .resp_err(resp_err_z)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request on the main instance and wait for its response
  // without completing the response handshake.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, output logic [31:0] rdata,
                               output logic err, output int lat);
    int guard;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 32'hFFFF_FFF0;
    req_wdata = ~wdata;
    req_be    = 4'hF;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF,    32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'hF,    32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,   32'h000000AA, 4'b0001, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10,   32'h0,        4'hF,    32'hDEADBEAA, 1'b0};
    vecs[4]  = '{1'b1, 32'h13,   32'h01234567, 4'hF,    32'h0,        1'b1};
    vecs[5]  = '{1'b0, 32'h1000, 32'h0,        4'hF,    32'h0,        1'b1};
    vecs[6]  = '{1'b1, 32'h10,   32'hFFFFFFFF, 4'h0,    32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h10,   32'h0,        4'hF,    32'hDEADBEAA, 1'b0};
    vecs[8]  = '{1'b1, 32'h20,   32'h11112222, 4'hF,    32'h0,        1'b0};
    vecs[9]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'b1010, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h20,   32'h0,        4'hF,    32'hAA11CC22, 1'b0};
    vecs[11] = '{1'b1, 32'hFFC,  32'h5A5A5A5A, 4'hF,    32'h0,        1'b0};
    vecs[12] = '{1'b0, 32'hFFC,  32'h0,        4'hF,    32'h5A5A5A5A, 1'b0};
    vecs[13] = '{1'b0, 32'h20,   32'h0,        4'h0,    32'h0,        1'b1};
    vecs[14] = '{1'b0, 32'h20,   32'h0,        4'b0001, 32'hAA11CC22, 1'b0};

    #2 rst = 1'b0;
    #1;
    checkOutput("reset req_ready",  32'(req_ready),  32'h0);
    checkOutput("reset resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("reset resp_rdata", resp_rdata,      32'h0);
    checkOutput("reset resp_err",   32'(resp_err),   32'h0);
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle req_ready", 32'(req_ready), 32'h1);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
      checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d back to idle", i), 32'(req_ready), 32'h1);
    end

    resp_ready = 1'b0;
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    checkOutput("bp latency", 32'(lat), 32'd3);
    checkOutput("bp rdata", rd, 32'hDEADBEAA);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp hold%0d resp_valid", k), 32'(resp_valid), 32'h1);
      checkOutput($sformatf("bp hold%0d rdata", k), resp_rdata, 32'hDEADBEAA);
      checkOutput($sformatf("bp hold%0d req_ready", k), 32'(req_ready), 32'h0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp release resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("bp release req_ready", 32'(req_ready), 32'h1);

    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    req_be    = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    checkOutput("midreset req_ready",  32'(req_ready),  32'h0);
    checkOutput("midreset resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("midreset resp_rdata", resp_rdata,      32'h0);
    checkOutput("midreset resp_err",   32'(resp_err),   32'h0);
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("postreset req_ready", 32'(req_ready), 32'h1);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    checkOutput("postreset latency", 32'(lat), 32'd3);
    checkOutput("postreset rdata", rd, 32'hAA11CC22);
    @(posedge clk); #1;

    req_valid_z  = 1'b1;
    req_we_z     = 1'b1;
    req_addr_z   = 32'h10;
    req_wdata_z  = 32'hCAFEF00D;
    req_be_z     = 4'hF;
    resp_ready_z = 1'b1;
    checkOutput("zw idle req_ready", 32'(req_ready_z), 32'h1);
    @(posedge clk); #1;
    req_we_z = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i > 1) begin
        @(posedge clk); #1;
      end
      case (i % 3)
        1: begin
          checkOutput($sformatf("zw c%0d resp_valid", i), 32'(resp_valid_z), 32'h0);
          checkOutput($sformatf("zw c%0d req_ready", i), 32'(req_ready_z), 32'h0);
        end
        2: begin
          checkOutput($sformatf("zw c%0d resp_valid", i), 32'(resp_valid_z), 32'h1);
          checkOutput($sformatf("zw c%0d rdata", i), resp_rdata_z,
                      (i == 2) ? 32'h0 : 32'hCAFEF00D);
        end
        default: begin
          checkOutput($sformatf("zw c%0d resp_valid", i), 32'(resp_valid_z), 32'h0);
          checkOutput($sformatf("zw c%0d req_ready", i), 32'(req_ready_z), 32'h1);
        end
      endcase
    end
    req_valid_z = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
